filter_sync_launcher: RTL and testbench
=======================================

Name: filter_sync_launcher

Overview:
- Source-domain (clk_a) stage that drives the bus feeding the bus filter synchronizer.
- Accepts bus updates through a valid/ready handshake and launches them onto a registered bus.
- Guarantees every launched value is held stable for at least HOLD_CYCLES clk_a cycles, so the clk_b-side filter always sees two equal consecutive samples.
- Coalesces updates that arrive during a hold window into a one-entry pending register.

Parameters:
- NUMBER_OF_BITS, 4, bus width.
- HOLD_CYCLES, 8, minimum clk_a cycles each bus_out value stays stable. Legal range is 2..255. Integration sets it to at least ceil(4*T_clk_b/T_clk_a)+1.
- OVERWRITE, 1. When 1, a newer update replaces the pending one and in_ready stays high. When 0, in_ready deasserts while pending is full.
- DROP_W, 8, width of the saturating drop counter.

Ports:
- clk_a  input  1  domain a clock.
- rstb_a  input  1  reset; asynchronous assert, active-low, clock clk_a.
- in_valid  input  1  update request.
- in_data  input  NUMBER_OF_BITS  update value.
- in_ready  output  1  update accepted when in_valid & in_ready at posedge clk_a.
- bus_out  output  NUMBER_OF_BITS  registered bus to the synchronizer (its bus_in).
- launch  output  1  one-cycle pulse, high in the cycle after bus_out changes.
- busy  output  1  high while in HOLD state.
- drop_cnt  output  DROP_W  count of pending values discarded by overwrite; saturates at all-ones.

Behaviour:
- Reset (rstb_a low, asynchronous) forces:
  - bus_out=0, launch=0, busy=0, drop_cnt=0
  - pend_valid=0, pend_data=0, hold_cnt=0
  - state=IDLE, so in_ready=1 once reset releases.
- Reset mid-hold discards any pending value; no launch follows release.
- All outputs are registered except in_ready, which is combinational from state and pend_valid:
  - IDLE: in_ready=1.
  - HOLD: in_ready = OVERWRITE ? 1 : ~pend_valid.
- States are IDLE and HOLD.
- IDLE, on accept:
  - in_data != bus_out: bus_out<=in_data, hold_cnt<=HOLD_CYCLES-1, launch<=1, go to HOLD. Latency is 1 edge.
  - in_data == bus_out: accepted, no launch, stay in IDLE.
- HOLD, when hold_cnt != 0:
  - hold_cnt decrements each edge.
  - An accept writes pend_data<=in_data, pend_valid<=1.
  - If pend_valid was already 1 (only possible with OVERWRITE=1), drop_cnt increments (saturating).
- HOLD, terminal edge (hold_cnt==0). The candidate is chosen first:
  - If an accept happens this edge, the candidate is in_data. An existing pending entry counts as a drop.
  - Otherwise, if pend_valid, the candidate is pend_data.
  - Otherwise there is no candidate.
- Terminal edge, then the candidate is applied:
  - Candidate exists and != bus_out: launch it, reload hold_cnt=HOLD_CYCLES-1, stay in HOLD.
  - Otherwise: go to IDLE.
  - pend_valid clears in both cases.
- Consequence: consecutive bus_out changes are at least HOLD_CYCLES edges apart, and a value never changes before its hold expires.
- bus_out changes only on a launch edge. All bits change on the same edge (single register).
- With OVERWRITE=0, no update is ever lost, and drop_cnt stays 0.
- busy=1 exactly while state==HOLD.

Test Plan (HOLD_CYCLES=4, NUMBER_OF_BITS=4):
- Reset release, then in_valid=1, in_data=0xA for one cycle -> bus_out=0xA one edge later, launch pulses 1 cycle, busy=1 for 4 cycles, then IDLE.
- Accept 0x3, then 0x5 one cycle later -> 0x3 held exactly 4 edges, then 0x5 launched; launch asserted twice, 4 edges apart.
- OVERWRITE=1: accept 0x1, then 0x2, 0x6, 0x7 on consecutive cycles -> bus_out sequence 0x1, then 0x7; drop_cnt=2; in_ready constantly 1.
- OVERWRITE=0, same stimulus -> in_ready low after 0x2 is pending; bus_out sequence 0x1, 0x2, 0x6, 0x7, each held 4 edges; drop_cnt=0.
- Accept value equal to current bus_out (0x0 after reset) -> no launch, busy stays 0. A pending value equal to bus_out at hold end -> return to IDLE, no launch.
- Assert rstb_a mid-hold with a pending 0x9 -> bus_out=0 immediately, no launch after release, in_ready=1; drop_cnt saturation checked with DROP_W=2 (stays at 3).

Source files
------------

// File: rtl/filter_sync_launcher.sv
// filter_sync_launcher
//   Source-domain (clk_a) launcher for the bus filter synchronizer. Accepts
//   bus updates through a valid/ready handshake and drives them onto a
//   registered bus. Each launched value is held for at least HOLD_CYCLES
//   clk_a cycles, so the clk_b-side filter always sees two equal consecutive
//   samples. Updates that arrive during a hold window are coalesced into a
//   one-entry pending register.
//
// Parameters
//   NUMBER_OF_BITS : bus width
//   HOLD_CYCLES    : minimum clk_a cycles each bus_out value is stable (2..255)
//   OVERWRITE      : 1 = newer update replaces the pending one and in_ready
//                    stays high; 0 = in_ready drops while pending is full
//   DROP_W         : width of the saturating drop counter
//
// Ports
//   clk_a    in   domain a clock
//   rstb_a   in   asynchronous active-low reset
//   in_valid in   update request
//   in_data  in   update value
//   in_ready out  update accepted when in_valid & in_ready at posedge clk_a
//   bus_out  out  registered bus to the synchronizer
//   launch   out  one-cycle pulse in the cycle after bus_out changes
//   busy     out  high while holding a launched value
//   drop_cnt out  saturating count of pending values discarded by overwrite
module filter_sync_launcher #(
  parameter int unsigned NUMBER_OF_BITS = 4,
  parameter int unsigned HOLD_CYCLES    = 8,
  parameter int unsigned OVERWRITE      = 1,
  parameter int unsigned DROP_W         = 8
) (
  input  logic                      clk_a,
  input  logic                      rstb_a,
  input  logic                      in_valid,
  input  logic [NUMBER_OF_BITS-1:0] in_data,
  output logic                      in_ready,
  output logic [NUMBER_OF_BITS-1:0] bus_out,
  output logic                      launch,
  output logic                      busy,
  output logic [DROP_W-1:0]         drop_cnt
);

  typedef enum logic {
    IDLE,
    HOLD
  } state_t;

  localparam logic [7:0] HOLD_RELOAD = 8'(HOLD_CYCLES - 1);

  state_t                    state, state_n;
  logic [7:0]                hold_cnt, hold_cnt_n;
  logic                      pend_valid, pend_valid_n;
  logic [NUMBER_OF_BITS-1:0] pend_data, pend_data_n;
  logic [NUMBER_OF_BITS-1:0] bus_n;
  logic                      launch_n;
  logic [DROP_W-1:0]         drop_n;
  logic                      accept;
  logic                      cand_valid;
  logic [NUMBER_OF_BITS-1:0] cand_data;

  always_comb begin
    in_ready = 1'b1;
    if (state == HOLD && OVERWRITE == 0) begin
      in_ready = ~pend_valid;
    end
  end

  assign accept = in_valid & in_ready;
  assign busy   = (state == HOLD);

  always_ff @(posedge clk_a or negedge rstb_a) begin
    if (!rstb_a) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      pend_valid <= 1'b0;
      pend_data  <= '0;
      bus_out    <= '0;
      launch     <= 1'b0;
      drop_cnt   <= '0;
    end else begin
      state      <= state_n;
      hold_cnt   <= hold_cnt_n;
      pend_valid <= pend_valid_n;
      pend_data  <= pend_data_n;
      bus_out    <= bus_n;
      launch     <= launch_n;
      drop_cnt   <= drop_n;
    end
  end

  always_comb begin
    state_n      = state;
    hold_cnt_n   = hold_cnt;
    pend_valid_n = pend_valid;
    pend_data_n  = pend_data;
    bus_n        = bus_out;
    launch_n     = 1'b0;
    drop_n       = drop_cnt;
    cand_valid   = 1'b0;
    cand_data    = pend_data;

    unique case (state)
      IDLE: begin
        if (accept && in_data != bus_out) begin
          bus_n      = in_data;
          hold_cnt_n = HOLD_RELOAD;
          launch_n   = 1'b1;
          state_n    = HOLD;
        end
      end

      HOLD: begin
        if (hold_cnt != 8'd0) begin
          hold_cnt_n = hold_cnt - 8'd1;
          if (accept) begin
            pend_data_n  = in_data;
            pend_valid_n = 1'b1;
            if (pend_valid && drop_cnt != '1) begin
              drop_n = drop_cnt + DROP_W'(1);
            end
          end
        end else begin
          // Terminal edge: a same-edge accept wins over the pending entry,
          // which then counts as dropped.
          if (accept) begin
            cand_valid = 1'b1;
            cand_data  = in_data;
            if (pend_valid && drop_cnt != '1) begin
              drop_n = drop_cnt + DROP_W'(1);
            end
          end else if (pend_valid) begin
            cand_valid = 1'b1;
            cand_data  = pend_data;
          end
          pend_valid_n = 1'b0;
          if (cand_valid && cand_data != bus_out) begin
            bus_n      = cand_data;
            hold_cnt_n = HOLD_RELOAD;
            launch_n   = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_filter_sync_launcher.sv
module tb_filter_sync_launcher;

  logic       clk_a;
  logic       rstb_a;

  // a: OVERWRITE=1, DROP_W=8
  logic       a_valid, a_ready, a_launch, a_busy;
  logic [3:0] a_data, a_bus;
  logic [7:0] a_drop;
  // b: OVERWRITE=0, DROP_W=8
  logic       b_valid, b_ready, b_launch, b_busy;
  logic [3:0] b_data, b_bus;
  logic [7:0] b_drop;
  // c: OVERWRITE=1, DROP_W=2
  logic       c_valid, c_ready, c_launch, c_busy;
  logic [3:0] c_data, c_bus;
  logic [1:0] c_drop;

  int errors = 0;
  int checks = 0;

  filter_sync_launcher #(.NUMBER_OF_BITS(4), .HOLD_CYCLES(4), .OVERWRITE(1), .DROP_W(8)) dut_a (
    .clk_a(clk_a), .rstb_a(rstb_a), .in_valid(a_valid), .in_data(a_data), .in_ready(a_ready),
    .bus_out(a_bus), .launch(a_launch), .busy(a_busy), .drop_cnt(a_drop));

  filter_sync_launcher #(.NUMBER_OF_BITS(4), .HOLD_CYCLES(4), .OVERWRITE(0), .DROP_W(8)) dut_b (
    .clk_a(clk_a), .rstb_a(rstb_a), .in_valid(b_valid), .in_data(b_data), .in_ready(b_ready),
    .bus_out(b_bus), .launch(b_launch), .busy(b_busy), .drop_cnt(b_drop));

  filter_sync_launcher #(.NUMBER_OF_BITS(4), .HOLD_CYCLES(4), .OVERWRITE(1), .DROP_W(2)) dut_c (
    .clk_a(clk_a), .rstb_a(rstb_a), .in_valid(c_valid), .in_data(c_data), .in_ready(c_ready),
    .bus_out(c_bus), .launch(c_launch), .busy(c_busy), .drop_cnt(c_drop));

  initial clk_a = 1'b0;
  always #5 clk_a = ~clk_a;

  task automatic tick();
    @(posedge clk_a);
    #1;
  endtask

  task automatic test_reset();
    rstb_a = 1'b0;
    a_valid = 1'b0; a_data = '0;
    b_valid = 1'b0; b_data = '0;
    c_valid = 1'b0; c_data = '0;
    #3;
    checks++; if (a_bus !== 4'h0) begin errors++; $display("FAIL reset_bus: got %0h expected 0", a_bus); end
    checks++; if (a_launch !== 1'b0) begin errors++; $display("FAIL reset_launch: got %0b expected 0", a_launch); end
    checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", a_busy); end
    checks++; if (a_drop !== 8'h00) begin errors++; $display("FAIL reset_drop: got %0h expected 0", a_drop); end
    tick();
    tick();
    rstb_a = 1'b1;
    #1;
    checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_a: got %0b expected 1", a_ready); end
    checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_b: got %0b expected 1", b_ready); end
  endtask

  task automatic test_single();
    a_valid = 1'b1; a_data = 4'hA;
    tick();
    a_valid = 1'b0;
    checks++; if (a_bus !== 4'hA) begin errors++; $display("FAIL single_bus: got %0h expected a", a_bus); end
    checks++; if (a_launch !== 1'b1) begin errors++; $display("FAIL single_launch: got %0b expected 1", a_launch); end
    checks++; if (a_busy !== 1'b1) begin errors++; $display("FAIL single_busy0: got %0b expected 1", a_busy); end
    for (int i = 1; i < 4; i++) begin
      tick();
      checks++; if (a_launch !== 1'b0 || a_busy !== 1'b1 || a_bus !== 4'hA) begin
        errors++; $display("FAIL single_hold%0d: got launch=%0b busy=%0b bus=%0h expected 0 1 a", i, a_launch, a_busy, a_bus);
      end
    end
    tick();
    checks++; if (a_busy !== 1'b0 || a_launch !== 1'b0 || a_bus !== 4'hA) begin
      errors++; $display("FAIL single_idle: got busy=%0b launch=%0b bus=%0h expected 0 0 a", a_busy, a_launch, a_bus);
    end
  endtask

  task automatic test_back_to_back();
    a_valid = 1'b1; a_data = 4'h3;
    tick();
    checks++; if (a_bus !== 4'h3 || a_launch !== 1'b1) begin
      errors++; $display("FAIL b2b_first: got bus=%0h launch=%0b expected 3 1", a_bus, a_launch);
    end
    a_data = 4'h5;
    tick();
    a_valid = 1'b0;
    for (int e = 1; e < 4; e++) begin
      if (e > 1) tick();
      checks++; if (a_bus !== 4'h3 || a_launch !== 1'b0) begin
        errors++; $display("FAIL b2b_hold%0d: got bus=%0h launch=%0b expected 3 0", e, a_bus, a_launch);
      end
    end
    tick();
    checks++; if (a_bus !== 4'h5 || a_launch !== 1'b1 || a_busy !== 1'b1) begin
      errors++; $display("FAIL b2b_second: got bus=%0h launch=%0b busy=%0b expected 5 1 1", a_bus, a_launch, a_busy);
    end
    repeat (4) tick();
    checks++; if (a_busy !== 1'b0 || a_bus !== 4'h5) begin
      errors++; $display("FAIL b2b_idle: got busy=%0b bus=%0h expected 0 5", a_busy, a_bus);
    end
  endtask

  task automatic test_overwrite();
    logic [3:0] vals [4];
    vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h6; vals[3] = 4'h7;
    for (int e = 0; e < 4; e++) begin
      a_valid = 1'b1; a_data = vals[e];
      #1;
      checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL ow_ready%0d: got %0b expected 1", e, a_ready); end
      tick();
      if (e == 0) begin
        checks++; if (a_bus !== 4'h1 || a_launch !== 1'b1) begin
          errors++; $display("FAIL ow_first: got bus=%0h launch=%0b expected 1 1", a_bus, a_launch);
        end
      end else begin
        checks++; if (a_bus !== 4'h1) begin errors++; $display("FAIL ow_hold%0d: got %0h expected 1", e, a_bus); end
      end
    end
    a_valid = 1'b0;
    checks++; if (a_drop !== 8'd2) begin errors++; $display("FAIL ow_drop: got %0d expected 2", a_drop); end
    tick();
    checks++; if (a_bus !== 4'h7 || a_launch !== 1'b1) begin
      errors++; $display("FAIL ow_second: got bus=%0h launch=%0b expected 7 1", a_bus, a_launch);
    end
    repeat (4) tick();
    checks++; if (a_busy !== 1'b0 || a_bus !== 4'h7 || a_drop !== 8'd2) begin
      errors++; $display("FAIL ow_end: got busy=%0b bus=%0h drop=%0d expected 0 7 2", a_busy, a_bus, a_drop);
    end
  endtask

  task automatic test_no_overwrite();
    logic [3:0] vals [4];
    logic [3:0] exp_bus;
    logic       exp_launch;
    logic       acc;
    int         idx;
    vals[0] = 4'h1; vals[1] = 4'h2; vals[2] = 4'h6; vals[3] = 4'h7;
    idx = 0;
    for (int e = 0; e < 17; e++) begin
      b_valid = (idx < 4);
      b_data  = (idx < 4) ? vals[idx] : 4'h0;
      #1;
      acc = b_valid && b_ready;
      tick();
      if (acc) idx++;
      exp_bus    = (e < 4) ? 4'h1 : (e < 8) ? 4'h2 : (e < 12) ? 4'h6 : 4'h7;
      exp_launch = (e % 4 == 0) && (e <= 12);
      checks++; if (b_bus !== exp_bus || b_launch !== exp_launch) begin
        errors++; $display("FAIL now_edge%0d: got bus=%0h launch=%0b expected %0h %0b", e, b_bus, b_launch, exp_bus, exp_launch);
      end
      if (e == 1) begin
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL now_ready_pending: got %0b expected 0", b_ready); end
      end
      if (e == 4) begin
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL now_ready_freed: got %0b expected 1", b_ready); end
      end
    end
    b_valid = 1'b0;
    checks++; if (b_busy !== 1'b0 || b_drop !== 8'd0 || idx != 4) begin
      errors++; $display("FAIL now_end: got busy=%0b drop=%0d accepted=%0d expected 0 0 4", b_busy, b_drop, idx);
    end
  endtask

  task automatic test_equal_value();
    c_valid = 1'b1; c_data = 4'h0;
    tick();
    c_valid = 1'b0;
    checks++; if (c_launch !== 1'b0 || c_busy !== 1'b0 || c_bus !== 4'h0 || c_ready !== 1'b1) begin
      errors++; $display("FAIL eq_idle: got launch=%0b busy=%0b bus=%0h ready=%0b expected 0 0 0 1", c_launch, c_busy, c_bus, c_ready);
    end
    a_valid = 1'b1; a_data = 4'h3;
    tick();
    checks++; if (a_bus !== 4'h3 || a_launch !== 1'b1) begin
      errors++; $display("FAIL eq_launch: got bus=%0h launch=%0b expected 3 1", a_bus, a_launch);
    end
    tick();
    a_valid = 1'b0;
    tick();
    tick();
    tick();
    checks++; if (a_busy !== 1'b0 || a_launch !== 1'b0 || a_bus !== 4'h3) begin
      errors++; $display("FAIL eq_pending: got busy=%0b launch=%0b bus=%0h expected 0 0 3", a_busy, a_launch, a_bus);
    end
  endtask

  task automatic test_reset_mid_hold();
    a_valid = 1'b1; a_data = 4'h8;
    tick();
    a_data = 4'h9;
    tick();
    a_valid = 1'b0;
    #2;
    rstb_a = 1'b0;
    #1;
    checks++; if (a_bus !== 4'h0 || a_busy !== 1'b0 || a_launch !== 1'b0 || a_drop !== 8'd0) begin
      errors++; $display("FAIL rst_mid: got bus=%0h busy=%0b launch=%0b drop=%0d expected 0 0 0 0", a_bus, a_busy, a_launch, a_drop);
    end
    #3;
    rstb_a = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (a_launch !== 1'b0 || a_bus !== 4'h0 || a_busy !== 1'b0 || a_ready !== 1'b1) begin
        errors++; $display("FAIL rst_after%0d: got launch=%0b bus=%0h busy=%0b ready=%0b expected 0 0 0 1", i, a_launch, a_bus, a_busy, a_ready);
      end
    end
  endtask

  task automatic test_drop_saturation();
    for (int e = 0; e < 8; e++) begin
      c_valid = 1'b1; c_data = 4'(e + 1);
      tick();
      if (e == 3) begin
        checks++; if (c_drop !== 2'd2) begin errors++; $display("FAIL sat_drop3: got %0d expected 2", c_drop); end
      end
      if (e == 4) begin
        checks++; if (c_drop !== 2'd3 || c_bus !== 4'h5 || c_launch !== 1'b1) begin
          errors++; $display("FAIL sat_edge4: got drop=%0d bus=%0h launch=%0b expected 3 5 1", c_drop, c_bus, c_launch);
        end
      end
    end
    c_valid = 1'b0;
    checks++; if (c_drop !== 2'd3) begin errors++; $display("FAIL sat_hold: got %0d expected 3", c_drop); end
    tick();
    checks++; if (c_bus !== 4'h8 || c_launch !== 1'b1 || c_drop !== 2'd3) begin
      errors++; $display("FAIL sat_final: got bus=%0h launch=%0b drop=%0d expected 8 1 3", c_bus, c_launch, c_drop);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_overwrite();
    test_no_overwrite();
    test_equal_value();
    test_reset_mid_hold();
    test_drop_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
